mips_mc_sequencer: RTL
======================

# mips_mc_sequencer

Multi-cycle sequencer for the MIPS core: a Moore/Mealy FSM that steps each instruction through FETCH, DECODE, EXEC, MEM and WB over a single shared memory port with a ready handshake. It issues the per-phase enables (PC, IR, register file, memory) alongside the combinational CONTROL decoder, which still supplies ALU op, mux selects and extend mode. It also detects illegal opcodes and memory time-outs, and counts retired instructions.

## Interface
Parameters:
- MAX_WAIT, 15: maximum consecutive not-ready cycles tolerated per memory transaction.
- WAIT_W, 4: width of the wait counter; must hold MAX_WAIT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- mem_ready  in  1  memory completed the current request this cycle.
- state  out  3  current FSM state, encoding from the package.
- mem_req  out  1  memory request.
- mem_we  out  1  write strobe, store phase only.
- addr_sel  out  1  memory address: 0 = PC, 1 = ALU result.
- ir_write  out  1  load IR from memory read data.
- pc_write  out  1  unconditional PC update.
- pc_write_cond  out  1  PC update gated by the datapath branch compare.
- pc_src  out  2  PC source: 00 = PC+4, 01 = branch target, 10 = jump target.
- reg_write  out  1  register file write enable.
- halted  out  1  sequencer stopped, sticky.
- illegal  out  1  halt cause: unsupported opcode.
- bus_error  out  1  halt cause: memory time-out.
- instret  out  32  count of retired instructions.

## Operation
- Opcode classes:
  - ALU: 000000, 001000, 001001, 001100, 001101, 001010, 001011.
  - LOAD: 100011, 100101, 100100.
  - STORE: 101011, 101001, 101000.
  - BRANCH: 000100, 000101.
  - J: 000010.
  - JAL: 000011.
  - Any other opcode is ILLEGAL.
- FETCH:
  - Outputs: mem_req=1, addr_sel=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=00, go to DECODE.
- DECODE (1 cycle):
  - J: pc_write=1, pc_src=10, go to FETCH.
  - JAL: pc_write=1, pc_src=10, reg_write=1 (link), go to FETCH.
  - ILLEGAL: go to HALT with illegal=1.
  - All other classes: go to EXEC.
- EXEC (1 cycle):
  - BRANCH: pc_write_cond=1, pc_src=01, go to FETCH.
  - LOAD or STORE: go to MEM.
  - ALU: go to WB.
- MEM:
  - Outputs: mem_req=1, addr_sel=1, mem_we=1 for STORE only.
  - On mem_ready: LOAD goes to WB; STORE goes to FETCH.
- WB (1 cycle): reg_write=1, go to FETCH.
- HALT:
  - All enables are 0 and halted=1.
  - HALT is left only by rst.
- Wait counter:
  - Cleared on entry to FETCH or MEM.
  - Increments on each cycle with mem_req=1 and mem_ready=0.
  - If mem_ready=0 while the counter equals MAX_WAIT, go to HALT with bus_error=1.
  - If mem_ready=1 on that same cycle, the transfer completes normally; ready wins.
- instret:
  - Increments on the cycle the FSM returns to FETCH from DECODE, EXEC, MEM or WB.
  - Wraps modulo 2^32.
  - Does not increment on entry to HALT.
- Illegal opcode and time-out are mutually exclusive by state, so at most one cause flag is set.

## Timing
- Reset values:
  - State is FETCH.
  - Counters, halted, illegal and bus_error are 0.
  - While rst=1, every enable output is forced to 0.
- First cycle after rst deasserts: mem_req=1, addr_sel=0.
- Handshake:
  - mem_req stays high and addr_sel/mem_we stay stable until mem_ready is sampled high.
  - mem_ready is ignored whenever mem_req=0.
- Enable timing: ir_write, pc_write, pc_write_cond and reg_write are single-cycle pulses coincident with the state transition they accompany.
- Cycles per instruction with zero-wait memory:
  - J/JAL: 2.
  - BRANCH: 3.
  - ALU: 4.
  - STORE: 4.
  - LOAD: 5.
  - Each not-ready cycle adds one.
- rst mid-instruction: the next cycle is FETCH, the partially executed instruction is discarded, and instret is cleared.

## Structure
- mips_pkg holds:
  - state encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7;
  - opcode constants;
  - pc_src encodings;
  - the class enumeration.
- One natural sub-module: opcode_class, a combinational opcode-to-class map shared with any future decoder.
- The top level holds the FSM, wait counter and instret.

## Test plan
- rst high for 2 cycles, then low; opcode=000000, mem_ready always 1:
  - states run FETCH, DECODE, EXEC, WB;
  - reg_write pulses in cycle 4;
  - instret=1 at cycle 5.
- opcode=100011 with mem_ready low for 3 cycles in MEM:
  - mem_req/addr_sel=1 held for 4 cycles;
  - then WB with reg_write=1;
  - 8 cycles total.
- opcode=000011 (JAL): DECODE cycle shows pc_write=1, pc_src=10, reg_write=1, and the next state is FETCH.
- opcode=111111:
  - DECODE leads to HALT with illegal=1 and halted=1;
  - mem_req stays 0 for 20 cycles;
  - instret is unchanged.
- mem_ready=0 in FETCH for MAX_WAIT+1 cycles gives HALT with bus_error=1. A repeat run with mem_ready=1 on exactly that cycle gives DECODE, with no error.
- rst asserted during MEM of a 101011 (store): mem_we drops the next cycle, state becomes FETCH, and instret=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS core: sequencer states, opcode
// constants, PC source selects and the opcode class enumeration.
package mips_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_J,
        CLS_JAL,
        CLS_ILLEGAL
    } op_class_t;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode-to-class map; anything not listed is illegal.
module opcode_class
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_t  op_class
);

    always_comb begin
        case (opcode)
            OP_RTYPE, OP_ADDI, OP_ADDIU, OP_ANDI,
            OP_ORI, OP_SLTI, OP_SLTIU:          op_class = CLS_ALU;
            OP_LW, OP_LHU, OP_LBU:              op_class = CLS_LOAD;
            OP_SW, OP_SH, OP_SB:                op_class = CLS_STORE;
            OP_BEQ, OP_BNE:                     op_class = CLS_BRANCH;
            OP_J:                               op_class = CLS_J;
            OP_JAL:                             op_class = CLS_JAL;
            default:                            op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mips_mc_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared
// memory port, with illegal-opcode and memory time-out halts and a retire count.
module mips_mc_sequencer
    import mips_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic [2:0]  state,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic        halted,
    output logic        illegal,
    output logic        bus_error,
    output logic [31:0] instret
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    state_t            cur_state;
    op_class_t         op_class;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timed_out;

    opcode_class u_opcode_class (
        .opcode   (opcode),
        .op_class (op_class)
    );

    assign state     = cur_state;
    assign halted    = (cur_state == S_HALT);
    assign timed_out = !mem_ready && (wait_cnt == WAIT_LIMIT);

    // NOTE: state and counters use non-blocking assignments so every branch
    // reads the pre-edge values, matching the flops they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= S_FETCH;
            wait_cnt  <= '0;
            instret   <= '0;
            illegal   <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            // Counter is zero whenever a transaction begins, since the cycle
            // before any entry to FETCH or MEM is never a waiting cycle.
            wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 1'b1 : '0;

            case (cur_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        cur_state <= S_DECODE;
                    end else if (timed_out) begin
                        cur_state <= S_HALT;
                        bus_error <= 1'b1;
                    end
                end
                S_DECODE: begin
                    case (op_class)
                        CLS_J, CLS_JAL: begin
                            cur_state <= S_FETCH;
                            instret   <= instret + 32'd1;
                        end
                        CLS_ILLEGAL: begin
                            cur_state <= S_HALT;
                            illegal   <= 1'b1;
                        end
                        default: cur_state <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    case (op_class)
                        CLS_BRANCH: begin
                            cur_state <= S_FETCH;
                            instret   <= instret + 32'd1;
                        end
                        CLS_LOAD, CLS_STORE: cur_state <= S_MEM;
                        default:             cur_state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (op_class == CLS_STORE) begin
                            cur_state <= S_FETCH;
                            instret   <= instret + 32'd1;
                        end else begin
                            cur_state <= S_WB;
                        end
                    end else if (timed_out) begin
                        cur_state <= S_HALT;
                        bus_error <= 1'b1;
                    end
                end
                S_WB: begin
                    cur_state <= S_FETCH;
                    instret   <= instret + 32'd1;
                end
                default: cur_state <= S_HALT;
            endcase
        end
    end

    // Enables depend on mem_ready so each pulse lands on the edge that
    // completes the transfer rather than one cycle later.
    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        addr_sel      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = PC_SRC_SEQ;
        reg_write     = 1'b0;
        if (!rst) begin
            case (cur_state)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_DECODE: begin
                    if (op_class == CLS_J || op_class == CLS_JAL) begin
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_JUMP;
                    end
                    reg_write = (op_class == CLS_JAL);
                end
                S_EXEC: begin
                    if (op_class == CLS_BRANCH) begin
                        pc_write_cond = 1'b1;
                        pc_src        = PC_SRC_BRANCH;
                    end
                end
                S_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = (op_class == CLS_STORE);
                end
                S_WB: reg_write = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
